// File: rtl/motion_window_scheduler_pkg.sv
// Shared scheduler types and defaults: FSM state encoding, timer sizing helper,
// and window/event defaults that the accumulator also uses.
package motion_sched_pkg;

  localparam int DEF_WINDOW_CYCLES = 120000;
  localparam int DEF_MIN_EVENTS    = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EARLY,
    S_LATE,
    S_TRIG,
    S_WAIT_MC,
    S_CLASSIFY,
    S_COOLDOWN
  } sched_state_e;

  // The timer has to hold the longer of one window and the whole cool-down span.
  function automatic int timer_w(input int window_cycles, input int cooldown_windows);
    int span;
    span = cooldown_windows * window_cycles;
    if (span < window_cycles) span = window_cycles;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/motion_window_scheduler_if.sv
// Accumulator / motion computer / classifier control bundle driven by the scheduler.
// The master side is the scheduler; the slave side is the processing chain.
interface motion_window_scheduler_if #(
  parameter int COUNT_BITS = 12
);
  logic                  acc_clear;
  logic                  acc_select_late;
  logic                  acc_freeze;
  logic                  mc_trigger;
  logic                  mc_valid;
  logic [COUNT_BITS-1:0] mc_total_events;
  logic                  cls_start;
  logic                  cls_done;

  modport master (
    output acc_clear, acc_select_late, acc_freeze, mc_trigger, cls_start,
    input  mc_valid, mc_total_events, cls_done
  );

  modport slave (
    input  acc_clear, acc_select_late, acc_freeze, mc_trigger, cls_start,
    output mc_valid, mc_total_events, cls_done
  );
endinterface

// File: rtl/motion_window_scheduler_window_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// One-cycle load latency, counting is held while en is low.
module window_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/motion_window_scheduler.sv
// Gesture-detection cycle sequencer: clear, early/late windows, motion compute, classify, cool-down.
// Outputs are registered from the next state, so they line up with the state they belong to.
module motion_window_scheduler
  import motion_sched_pkg::*;
#(
  parameter int WINDOW_CYCLES    = DEF_WINDOW_CYCLES,
  parameter int COUNT_BITS       = 12,
  parameter int MIN_EVENTS       = DEF_MIN_EVENTS,
  parameter int COOLDOWN_WINDOWS = 4,
  parameter int MC_TIMEOUT       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  motion_window_scheduler_if.master  bus,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 gesture_count
);

  localparam int TW  = timer_w(WINDOW_CYCLES, COOLDOWN_WINDOWS);
  localparam int TOW = $clog2(MC_TIMEOUT + 1);
  localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] CD_LOAD  = (COOLDOWN_WINDOWS == 0) ? '0 :
                                       TW'(COOLDOWN_WINDOWS * WINDOW_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] MIN_EV  = COUNT_BITS'(MIN_EVENTS);
  localparam logic [TOW-1:0]        TO_LAST = TOW'(MC_TIMEOUT - 1);

  sched_state_e  state, next_state;
  logic [TOW-1:0] tmo_cnt;
  logic          timeout_hit;
  logic          tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_val;
  logic          clear_d, late_d, freeze_d, trig_d, cls_d, busy_d;

  window_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      tmo_cnt             <= '0;
      timeout_err         <= 1'b0;
      gesture_count       <= 8'd0;
      busy                <= 1'b0;
      bus.acc_clear       <= 1'b0;
      bus.acc_select_late <= 1'b0;
      bus.acc_freeze      <= 1'b0;
      bus.mc_trigger      <= 1'b0;
      bus.cls_start       <= 1'b0;
    end else begin
      state               <= next_state;
      // tmo_cnt equals the number of cycles since the trigger cycle while waiting.
      tmo_cnt             <= (next_state == S_WAIT_MC) ? tmo_cnt + TOW'(1) : '0;
      busy                <= busy_d;
      bus.acc_clear       <= clear_d;
      bus.acc_select_late <= late_d;
      bus.acc_freeze      <= freeze_d;
      bus.mc_trigger      <= trig_d;
      bus.cls_start       <= cls_d;
      if (timeout_hit) timeout_err <= 1'b1;
      if (cls_d) gesture_count <= gesture_count + 8'd1;
    end
  end

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:     if (enable) next_state = S_CLEAR;
      S_CLEAR:    next_state = enable ? S_EARLY : S_IDLE;
      S_EARLY: begin
        if (!enable)     next_state = S_IDLE;
        else if (tmr_tc) next_state = S_LATE;
      end
      S_LATE: begin
        if (!enable)     next_state = S_IDLE;
        else if (tmr_tc) next_state = S_TRIG;
      end
      S_TRIG:     next_state = S_WAIT_MC;
      S_WAIT_MC: begin
        if (bus.mc_valid) begin
          if (bus.mc_total_events >= MIN_EV) next_state = S_CLASSIFY;
          else                               next_state = enable ? S_CLEAR : S_IDLE;
        end else if (tmo_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          next_state  = enable ? S_CLEAR : S_IDLE;
        end
      end
      S_CLASSIFY: begin
        if (bus.cls_done) begin
          if (!enable)                   next_state = S_IDLE;
          else if (COOLDOWN_WINDOWS == 0) next_state = S_CLEAR;
          else                           next_state = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (!enable)     next_state = S_IDLE;
        else if (tmr_tc) next_state = S_CLEAR;
      end
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    clear_d  = (next_state == S_CLEAR) || (next_state == S_COOLDOWN);
    late_d   = (next_state == S_LATE) || (next_state == S_TRIG);
    freeze_d = (next_state == S_TRIG) || (next_state == S_WAIT_MC) ||
               (next_state == S_CLASSIFY);
    trig_d   = (next_state == S_TRIG);
    cls_d    = (next_state == S_CLASSIFY) && (state != S_CLASSIFY);
    busy_d   = (next_state != S_IDLE);
    // Timer is reloaded on entry to any timed state and free-runs down otherwise.
    tmr_load = (next_state != state) &&
               ((next_state == S_EARLY) || (next_state == S_LATE) ||
                (next_state == S_COOLDOWN));
    tmr_en   = !tmr_load;
    tmr_val  = (next_state == S_COOLDOWN) ? CD_LOAD : WIN_LOAD;
  end

endmodule

// File: tb/tb_motion_window_scheduler.sv
// Randomized bench for motion_window_scheduler; expected timelines come from
// window/cool-down/timeout arithmetic and a running classification count.
module tb_motion_window_scheduler;

  localparam int W    = 8;
  localparam int MINE = 4;
  localparam int CDW  = 2;
  localparam int TO   = 8;
  localparam int CB   = 12;

  // Output vector order: {acc_clear, select_late, freeze, trigger, cls_start, busy}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_CLEAR = 6'b100001;
  localparam logic [5:0] O_EARLY = 6'b000001;
  localparam logic [5:0] O_LATE  = 6'b010001;
  localparam logic [5:0] O_TRIG  = 6'b011101;
  localparam logic [5:0] O_WAIT  = 6'b001001;
  localparam logic [5:0] O_CLS1  = 6'b001011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       busy, timeout_err;
  logic [7:0] gesture_count;

  int n_chk = 0;
  int n_bad = 0;
  int exp_g = 0;
  int n_cls = 0;
  bit exp_tmo = 1'b0;

  motion_window_scheduler_if #(.COUNT_BITS(CB)) bus ();

  motion_window_scheduler #(
    .WINDOW_CYCLES(W), .COUNT_BITS(CB), .MIN_EVENTS(MINE),
    .COOLDOWN_WINDOWS(CDW), .MC_TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .bus           (bus.master),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .gesture_count (gesture_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_o(input string tag, input logic [5:0] e);
    chk(tag, {bus.acc_clear, bus.acc_select_late, bus.acc_freeze,
              bus.mc_trigger, bus.cls_start, busy}, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left in the CLEAR cycle; vd >= TO withholds mc_valid.
  task automatic run_cycle(input int vd, input int tot, input int dd,
                           input bit drop, input bit stray);
    chk_o("clear", O_CLEAR);
    for (int k = 0; k < W; k++) begin
      step();
      bus.mc_valid = 1'b0;
      bus.cls_done = 1'b0;
      chk_o("early", O_EARLY);
      if (stray && ($urandom_range(0, 1) == 1)) begin
        bus.mc_valid        = 1'b1;
        bus.mc_total_events = CB'($urandom_range(0, 4095));
        bus.cls_done        = 1'b1;
      end
    end
    for (int k = 0; k < W; k++) begin
      step();
      bus.mc_valid = 1'b0;
      bus.cls_done = 1'b0;
      chk_o("late", O_LATE);
    end
    step();
    chk_o("trig", O_TRIG);
    chk("tmo_hold", timeout_err, exp_tmo);
    if (vd < TO) begin
      for (int k = 1; k <= vd; k++) begin
        step();
        chk_o("wait", O_WAIT);
        if (k == vd) begin
          bus.mc_valid        = 1'b1;
          bus.mc_total_events = CB'(tot);
          if (drop) enable = 1'b0;
        end
      end
      step();
      bus.mc_valid = 1'b0;
      if (tot >= MINE) begin
        exp_g = (exp_g + 1) % 256;
        n_cls++;
        chk_o("cls_first", O_CLS1);
        chk("gcount", gesture_count, exp_g);
        for (int j = 0; j <= dd; j++) begin
          if (j > 0) begin
            step();
            chk_o("cls_wait", O_WAIT);
          end
          if (j == dd) bus.cls_done = 1'b1;
        end
        step();
        bus.cls_done = 1'b0;
        if (!drop) begin
          for (int i = 0; i < CDW * W; i++) begin
            if (i > 0) step();
            chk_o("cool", O_CLEAR);
          end
          step();
        end
      end
    end else begin
      for (int k = 1; k < TO; k++) begin
        step();
        chk_o("wait_to", O_WAIT);
        chk("tmo_pre", timeout_err, exp_tmo);
        if (k == 1 && drop) enable = 1'b0;
      end
      step();
      exp_tmo = 1'b1;
      chk("tmo_set", timeout_err, 1);
    end
    if (drop) begin
      chk_o("idle", O_IDLE);
      enable = 1'b1;
      step();
    end
    chk("gcount_end", gesture_count, exp_g);
  endtask

  // Drops enable in EARLY cycle k, then restarts; entered and left in CLEAR.
  task automatic early_drop(input int k);
    chk_o("clear_ed", O_CLEAR);
    for (int i = 1; i <= k; i++) begin
      step();
      chk_o("early_ed", O_EARLY);
    end
    enable = 1'b0;
    step();
    chk_o("idle_ed", O_IDLE);
    step();
    chk_o("idle_hold", O_IDLE);
    enable = 1'b1;
    step();
  endtask

  initial begin
    bus.mc_valid        = 1'b0;
    bus.cls_done        = 1'b0;
    bus.mc_total_events = '0;
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      step();
      chk_o("rst", O_IDLE);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_gc", gesture_count, 0);
    end
    rst_n = 1'b1;
    step();
    chk_o("rel_clear", O_CLEAR);

    run_cycle(2, 10, $urandom_range(0, 3), 1'b0, 1'b0);
    run_cycle(2, 3, 0, 1'b0, 1'b0);
    run_cycle(9, 0, 0, 1'b0, 1'b0);
    run_cycle(1, MINE, 0, 1'b0, 1'b1);
    run_cycle(TO - 1, MINE, 2, 1'b0, 1'b0);
    early_drop(3);
    run_cycle(2, 10, 1, 1'b1, 1'b0);
    run_cycle(9, 0, 0, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0)
        early_drop($urandom_range(1, W));
      else
        run_cycle($urandom_range(1, 9), $urandom_range(0, 15), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
    end

    while (n_cls < 256)
      run_cycle($urandom_range(1, 3), $urandom_range(MINE, 4095), $urandom_range(0, 2),
                1'b0, $urandom_range(0, 1) == 1);
    chk("wrap", gesture_count, 0);
    chk_o("post_wrap", O_CLEAR);

    rst_n = 1'b0;
    step();
    chk_o("rst2", O_IDLE);
    chk("rst2_tmo", timeout_err, 0);
    chk("rst2_gc", gesture_count, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
